fp_result_collector: RTL
========================

# fp_result_collector

Downstream stage of the floating-point adder. Watches the adder's progress indicator, `data_out` and `status_out`, and captures each completed result exactly once. Buffers captured results in a small FIFO behind a valid/ready handshake. Optionally keeps per-status statistics counters for the 32-bit custom format (1 sign bit, 6-bit exponent [30:25], 25-bit mantissa [24:0]).

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clock_100kHz` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `qual_lugar_in` in 3: adder stage indicator. 5 = FINALIZE done, 4 = CHECK done.
- `data_in` in 32: adder `data_out`.
- `status_in` in 4: adder `status_out`. 0 exact, 1 overflow, 2 underflow, 3 inexact.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer accepts the head.
- `res_data` out 32: head result word.
- `res_status` out 4: head status.
- `fifo_level` out $clog2(DEPTH)+1: current occupancy.
- `drop_sticky` out 1: a capture was lost because the FIFO was full.
- `seq_err_sticky` out 1: the indicator left 5 without passing through 4.
- `cnt_exact`, `cnt_overflow`, `cnt_underflow`, `cnt_inexact` out CNT_W each: saturating event counters.

## Operation
- Capture FSM states:
  - WAIT_FIN: on sampled `qual_lugar_in==5`, go to WAIT_CHK.
  - WAIT_CHK, sampled value 4: capture `{data_in, status_in}` at that edge and return to WAIT_FIN.
  - WAIT_CHK, sampled value 5: stay in WAIT_CHK.
  - WAIT_CHK, any other value: set `seq_err_sticky`, return to WAIT_FIN, no capture.
- A value of 4 seen in WAIT_FIN is ignored. This gives exactly one capture per adder pass, however long the adder dwells in a state.
- FIFO:
  - Circular buffer with separate read and write pointers, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
  - Show-ahead: `res_data` and `res_status` are combinational from the read pointer and are valid whenever `res_valid` is 1.
  - Pop occurs when `res_valid && res_ready`.
  - `res_valid = (fifo_level != 0)`.
- Boundary rules:
  - Capture when full with no pop in the same cycle: entry discarded, `drop_sticky` set, level unchanged.
  - Capture and pop in the same cycle while full: both succeed, level stays DEPTH.
  - Capture and pop in the same cycle while empty: the capture is written and the pop does not occur, because `res_valid` was 0.
  - `res_ready` while empty: no effect.
- Sticky flags clear only on reset.
- `status_in` values above 3: the entry is stored, but no counter increments.

## Timing
- Reset values: FSM in WAIT_FIN; both pointers 0; `fifo_level` 0; `res_valid` 0; `res_data` and `res_status` 0 (storage cleared); both stickies 0; all counters 0.
- Latency: `res_valid` rises in the cycle after the capture edge. That is one clock after `qual_lugar_in` first samples as 4.
- Throughput: one capture and one pop per cycle.
- Reset asserted mid-pass: everything returns to reset values immediately. The next capture requires a fresh 5→4 sequence.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Configuration
- Macro `FP_COLLECTOR_STATS_EN`.
  - Defined: the four counters increment on each capture, including dropped captures, selected by `status_in`.
  - Undefined: the counter registers are not built and the four outputs are tied to 0. The FIFO and the flags are unaffected.

## Structure
- Shared package `fp_pkg`:
  - Status code constants: `FP_ST_EXACT`=0, `FP_ST_OVF`=1, `FP_ST_UNF`=2, `FP_ST_INEXACT`=3.
  - Stage indicator constants: `FP_STG_FINALIZE`=5, `FP_STG_CHECK`=4.
  - Packed struct `fp_result_t` of `{data[31:0], status[3:0]}`.
  - Capture FSM enum.
- One sub-module: `fp_result_fifo`, the parameterised show-ahead FIFO. Its ports are push, pop, full, empty, level and a drop pulse.

## Test plan
- Single pass: drive `qual_lugar_in` through 0,1,2,3,5,4 with `data_in`=0x40000000 (1.0+1.0) and `status_in`=0. Expect `res_valid`=1 one cycle after 4 is sampled, `res_data`=0x40000000, `res_status`=0, and `cnt_exact`=1.
- Dwell: hold 5 for 3 cycles and 4 for 3 cycles. Expect exactly one entry, `fifo_level`=1.
- Overflow: 9 passes with `res_ready`=0 and DEPTH=8. Expect `fifo_level`=8 and `drop_sticky`=1. Then pop 8 times and expect the first 8 words in order.
- Full with simultaneous capture and pop: expect `fifo_level` stays 8 and `drop_sticky` stays 0.
- Sequence error: 5 followed directly by 0. Expect `seq_err_sticky`=1 and no entry.
- Reset mid-stream: assert `reset` with 3 entries queued. Expect `fifo_level`=0, `res_valid`=0 and counters 0 in the same cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder result path: status codes, stage
// indicator values, the stored result record and the capture FSM states.
package fp_pkg;

  localparam logic [3:0] FP_ST_EXACT   = 4'd0;
  localparam logic [3:0] FP_ST_OVF     = 4'd1;
  localparam logic [3:0] FP_ST_UNF     = 4'd2;
  localparam logic [3:0] FP_ST_INEXACT = 4'd3;

  localparam logic [2:0] FP_STG_FINALIZE = 3'd5;
  localparam logic [2:0] FP_STG_CHECK    = 3'd4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  status;
  } fp_result_t;

  typedef enum logic [0:0] {
    StWaitFin,
    StWaitChk
  } cap_state_e;

endpackage

// File: rtl/fp_result_fifo.sv
// Show-ahead circular FIFO of fp_result_t entries. A push into a full FIFO succeeds only
// when a pop happens in the same cycle; otherwise it is discarded and drop pulses.
module fp_result_fifo
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  fp_result_t      wdata,
  input  logic            pop,
  output fp_result_t      rdata,
  output logic            full,
  output logic            empty,
  output logic [LvlW-1:0] level,
  output logic            drop
);

  fp_result_t      mem_q [DEPTH];
  fp_result_t      mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LvlW'(DEPTH));
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    // A pop on an empty FIFO is ignored, so a same-cycle push into empty never pops.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// Captures one result per adder pass (FINALIZE then CHECK) into a show-ahead FIFO.
// Define FP_COLLECTOR_STATS_EN to build the saturating per-status event counters.
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clock_100kHz,
  input  logic                     reset,
  input  logic [2:0]               qual_lugar_in,
  input  logic [31:0]              data_in,
  input  logic [3:0]               status_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [3:0]               res_status,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     drop_sticky,
  output logic                     seq_err_sticky,
  output logic [CNT_W-1:0]         cnt_exact,
  output logic [CNT_W-1:0]         cnt_overflow,
  output logic [CNT_W-1:0]         cnt_underflow,
  output logic [CNT_W-1:0]         cnt_inexact
);

  cap_state_e state_q, state_d;
  logic       capture, seq_err;
  logic       drop_sticky_q, drop_sticky_d;
  logic       seq_err_sticky_q, seq_err_sticky_d;
  logic       fifo_full, fifo_empty, fifo_drop;
  logic       unused_fifo_full;
  fp_result_t fifo_wdata, fifo_rdata;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    seq_err = 1'b0;
    case (state_q)
      StWaitFin: begin
        // CHECK seen here is a dwell tail of an already-captured pass; ignore it.
        if (qual_lugar_in == FP_STG_FINALIZE) begin
          state_d = StWaitChk;
        end
      end
      StWaitChk: begin
        if (qual_lugar_in == FP_STG_CHECK) begin
          capture = 1'b1;
          state_d = StWaitFin;
        end else if (qual_lugar_in != FP_STG_FINALIZE) begin
          seq_err = 1'b1;
          state_d = StWaitFin;
        end
      end
      default: state_d = StWaitFin;
    endcase
  end

  always_comb begin
    drop_sticky_d    = drop_sticky_q | fifo_drop;
    seq_err_sticky_d = seq_err_sticky_q | seq_err;
  end

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      state_q          <= StWaitFin;
      drop_sticky_q    <= 1'b0;
      seq_err_sticky_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      drop_sticky_q    <= drop_sticky_d;
      seq_err_sticky_q <= seq_err_sticky_d;
    end
  end

  assign fifo_wdata = '{data: data_in, status: status_in};

  fp_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock_100kHz),
    .rst   (reset),
    .push  (capture),
    .wdata (fifo_wdata),
    .pop   (res_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .drop  (fifo_drop)
  );

  assign unused_fifo_full = fifo_full;
  assign res_valid        = !fifo_empty;
  assign res_data         = fifo_rdata.data;
  assign res_status       = fifo_rdata.status;
  assign drop_sticky      = drop_sticky_q;
  assign seq_err_sticky   = seq_err_sticky_q;

`ifdef FP_COLLECTOR_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Dropped captures still count: the counters track adder outcomes, not FIFO contents.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && (status_in[3:2] == 2'b00)) begin
      if (cnt_q[status_in[1:0]] != '1) begin
        cnt_d[status_in[1:0]] = cnt_q[status_in[1:0]] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_exact     = cnt_q[FP_ST_EXACT[1:0]];
  assign cnt_overflow  = cnt_q[FP_ST_OVF[1:0]];
  assign cnt_underflow = cnt_q[FP_ST_UNF[1:0]];
  assign cnt_inexact   = cnt_q[FP_ST_INEXACT[1:0]];
`else
  assign cnt_exact     = '0;
  assign cnt_overflow  = '0;
  assign cnt_underflow = '0;
  assign cnt_inexact   = '0;
`endif

endmodule
